hilo_muldiv: RTL
================

Name: hilo_muldiv

Overview:
EX-stage consumer of the decoder's 8-bit hilo_op bundle. Owns the architectural HI/LO registers and serves mfhi/mflo/mthi/mtlo. Executes mult/multu on a registered multiplier and div/divu on an iterative radix-2 restoring divider. Raises stallreq to the pipeline stall controller while an operation is in flight.

Parameters:
MUL_CYCLES, 1, number of cycles spent in the MUL state (legal values 1..4).
DIV_ITER, 32, number of divider iterations (fixed at 32; other values are unsupported).

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
valid_i  in  1  EX holds a real instruction this cycle
hilo_op  in  8  {mfhi, mflo, mthi, mtlo, mult, multu, div, divu}; one-hot or all zero
src1  in  32  rs value after forwarding
src2  in  32  rt value after forwarding
stall_ex  in  1  a later stage is holding EX; the instruction does not leave EX this cycle
flush  in  1  cancel the EX instruction
hilo_rdata  out  32  HI for mfhi, LO for mflo, 0 otherwise
stallreq  out  1  hold IF..EX; mult/div still computing
busy  out  1  state != IDLE

Behaviour:
- Reset (rst=1 at a clk edge):
  - HI=0, LO=0, state=IDLE, iteration counter=0.
  - stallreq=0 and busy=0 on the next cycle.
  - Reset mid-operation abandons the operation and writes nothing.
- hilo_rdata is combinational from the current HI/LO and needs no bypass, because all writes commit at the edge ending the producing instruction's EX cycle.
- start = valid_i & state==IDLE & (mult|multu|div|divu) & ~flush.
- mthi/mtlo:
  - Applies when valid_i & IDLE & ~stall_ex & ~flush.
  - HI<=src1 or LO<=src1 at the end of that cycle.
  - No stall.
- States: IDLE, MUL, DIV, DONE.
  - IDLE -> MUL on start with mult/multu. Captures operands and signedness.
  - IDLE -> DIV on start with div/divu. Captures |src1| and |src2| (magnitudes for div; raw values for divu), the sign of src1, the sign of src1^src2, and counter=0.
  - MUL: computes the 64-bit product (signed for mult, unsigned for multu) into a result register. Goes to DONE after MUL_CYCLES cycles.
  - DIV: one restoring step per cycle, building a 32-bit quotient and remainder. Goes to DONE when counter reaches DIV_ITER-1.
  - In the final cycle, apply the sign fix: negate the quotient if the signs differ; the remainder takes the sign of the dividend.
  - DONE:
    - Result held and stallreq=0.
    - New starts are ignored (the same instruction is still in EX).
    - If stall_ex=1, stay in DONE.
    - Otherwise go to IDLE and, unless flush, commit. Multiply: HI<=prod[63:32], LO<=prod[31:0]. Divide: HI<=remainder, LO<=quotient.
- stallreq = ~flush & (start | state==MUL | state==DIV).
  - Multiply stalls 1+MUL_CYCLES cycles.
  - Divide stalls 33 cycles.
  - The instruction leaves EX in the first DONE cycle with stall_ex=0.
- flush=1 in any state:
  - Next state is IDLE.
  - No HI/LO write.
  - stallreq=0 in that cycle.
- Divide by zero:
  - Runs the full 33 cycles.
  - Result is LO=32'hFFFF_FFFF, HI=src1 (the original value) for both div and divu.
- Signed overflow 0x8000_0000 / 0xFFFF_FFFF (div): LO=0x8000_0000, HI=0.
- valid_i=0 or hilo_op=0: no action, hilo_rdata=0.
- The HI/LO value does not change between start and commit.

Test Plan:
- Reset, then mthi src1=0x1234_5678, then mfhi -> hilo_rdata=0x1234_5678 in the mfhi cycle; stallreq stays 0 throughout.
- mult src1=0xFFFF_FFFE (-2), src2=3 with MUL_CYCLES=1 -> stallreq high 2 cycles, DONE on cycle 3; then HI=0xFFFF_FFFF, LO=0xFFFF_FFFA. multu with the same operands -> HI=0x0000_0002, LO=0xFFFF_FFFA.
- div src1=0xFFFF_FFF9 (-7), src2=2 -> stallreq high exactly 33 cycles; LO=0xFFFF_FFFD (-3), HI=0xFFFF_FFFF (-1). divu 100/7 -> LO=14, HI=2.
- divu src2=0, src1=0xABCD -> 33-cycle stall, then LO=0xFFFF_FFFF, HI=0xABCD. div 0x8000_0000/-1 -> LO=0x8000_0000, HI=0.
- Start div, assert flush at iteration 10 -> stallreq=0 that cycle, state IDLE next cycle, HI/LO unchanged. Repeat with rst at iteration 10 -> HI=LO=0, busy=0.
- mult completes into DONE with stall_ex=1 for 3 cycles -> no restart, no write while held; HI/LO written on the cycle stall_ex drops. A following mflo then reads the new LO.

Source files
------------

// File: rtl/hilo_muldiv_if.sv
// EX-stage handshake bundle between the pipeline and the HI/LO mult/div unit.
interface hilo_muldiv_if;
   logic        valid_i;
   logic [7:0]  hilo_op;     // {mfhi, mflo, mthi, mtlo, mult, multu, div, divu}
   logic [31:0] src1;
   logic [31:0] src2;
   logic        stall_ex;
   logic        flush;
   logic [31:0] hilo_rdata;
   logic        stallreq;
   logic        busy;

   modport master (
      output valid_i, hilo_op, src1, src2, stall_ex, flush,
      input  hilo_rdata, stallreq, busy
   );

   modport slave (
      input  valid_i, hilo_op, src1, src2, stall_ex, flush,
      output hilo_rdata, stallreq, busy
   );
endinterface

// File: rtl/hilo_muldiv.sv
// HI/LO register owner: mfhi/mflo/mthi/mtlo, registered multiplier and a
// 32-step radix-2 restoring divider. Results commit when the instruction
// finally leaves EX, so HI/LO never change while an operation is in flight.
module hilo_muldiv #(
   parameter int MUL_CYCLES = 1,
   parameter int DIV_ITER   = 32
) (
   input  logic          clk,
   input  logic          rst,
   hilo_muldiv_if.slave  bus
);
   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

   localparam logic [4:0] MUL_LAST = 5'(MUL_CYCLES - 1);
   localparam logic [4:0] DIV_LAST = 5'(DIV_ITER - 1);

   state_t      state_q, state_d;
   logic [31:0] hi_q, hi_d, lo_q, lo_d;
   logic [4:0]  cnt_q, cnt_d;
   // opa: multiplicand, or dividend magnitude that shifts into the quotient
   // opb: multiplier, or divisor magnitude
   logic [31:0] opa_q, opa_d, opb_q, opb_d;
   logic [31:0] rem_q, rem_d;
   logic [31:0] res_hi_q, res_hi_d, res_lo_q, res_lo_d;
   logic        mul_signed_q, mul_signed_d;
   logic        neg_quot_q, neg_quot_d;
   logic        neg_rem_q, neg_rem_d;

   logic op_mfhi, op_mflo, op_mthi, op_mtlo, op_mult, op_multu, op_div, op_divu;
   logic is_mul_op, is_div_op, start;
   logic src1_neg, src2_neg;

   assign {op_mfhi, op_mflo, op_mthi, op_mtlo, op_mult, op_multu, op_div, op_divu} = bus.hilo_op;
   assign is_mul_op = op_mult | op_multu;
   assign is_div_op = op_div  | op_divu;
   assign start     = bus.valid_i & (state_q == S_IDLE) & (is_mul_op | is_div_op) & ~bus.flush;
   assign src1_neg  = op_div & bus.src1[31];
   assign src2_neg  = op_div & bus.src2[31];

   assign bus.stallreq   = ~bus.flush & (start | (state_q == S_MUL) | (state_q == S_DIV));
   assign bus.busy       = (state_q != S_IDLE);
   assign bus.hilo_rdata = (bus.valid_i && op_mfhi) ? hi_q :
                           (bus.valid_i && op_mflo) ? lo_q : 32'd0;

   // 64x64 low half equals the 32x32 product once operands are extended by signedness
   logic [63:0] mul_a, mul_b, prod;
   assign mul_a = {{32{mul_signed_q & opa_q[31]}}, opa_q};
   assign mul_b = {{32{mul_signed_q & opb_q[31]}}, opb_q};
   assign prod  = mul_a * mul_b;

   // One restoring step: shift in the next dividend bit, subtract if it fits
   logic [32:0] rem_shift, rem_sub;
   logic        step_ok;
   logic [31:0] new_rem, new_quot, q_fix, r_fix;
   assign rem_shift = {rem_q, opa_q[31]};
   assign rem_sub   = rem_shift - {1'b0, opb_q};
   assign step_ok   = ~rem_sub[32];
   assign new_rem   = step_ok ? rem_sub[31:0] : rem_shift[31:0];
   assign new_quot  = {opa_q[30:0], step_ok};
   // A zero divisor leaves an all-ones quotient unsigned; the remainder fix
   // then restores the original dividend on its own.
   assign q_fix = (neg_quot_q && opb_q != 32'd0) ? (32'd0 - new_quot) : new_quot;
   assign r_fix = neg_rem_q ? (32'd0 - new_rem) : new_rem;

   // Next-state, operand capture, datapath steps and HI/LO commit
   always_comb begin
      state_d      = state_q;
      hi_d         = hi_q;
      lo_d         = lo_q;
      cnt_d        = cnt_q;
      opa_d        = opa_q;
      opb_d        = opb_q;
      rem_d        = rem_q;
      res_hi_d     = res_hi_q;
      res_lo_d     = res_lo_q;
      mul_signed_d = mul_signed_q;
      neg_quot_d   = neg_quot_q;
      neg_rem_d    = neg_rem_q;
      case (state_q)
         S_IDLE: begin
            if (bus.valid_i && !bus.stall_ex && !bus.flush) begin
               if (op_mthi) hi_d = bus.src1;
               if (op_mtlo) lo_d = bus.src1;
            end
            if (start) begin
               cnt_d = 5'd0;
               if (is_mul_op) begin
                  opa_d        = bus.src1;
                  opb_d        = bus.src2;
                  mul_signed_d = op_mult;
                  state_d      = S_MUL;
               end else begin
                  opa_d      = src1_neg ? (32'd0 - bus.src1) : bus.src1;
                  opb_d      = src2_neg ? (32'd0 - bus.src2) : bus.src2;
                  rem_d      = 32'd0;
                  neg_quot_d = src1_neg ^ src2_neg;
                  neg_rem_d  = src1_neg;
                  state_d    = S_DIV;
               end
            end
         end
         S_MUL: begin
            res_hi_d = prod[63:32];
            res_lo_d = prod[31:0];
            cnt_d    = cnt_q + 5'd1;
            if (cnt_q == MUL_LAST) state_d = S_DONE;
         end
         S_DIV: begin
            opa_d = new_quot;
            rem_d = new_rem;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == DIV_LAST) begin
               res_hi_d = r_fix;
               res_lo_d = q_fix;
               state_d  = S_DONE;
            end
         end
         S_DONE: begin
            if (!bus.stall_ex) begin
               state_d = S_IDLE;
               if (!bus.flush) begin
                  hi_d = res_hi_q;
                  lo_d = res_lo_q;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (bus.flush) state_d = S_IDLE;
   end

   // State registers; reset abandons any operation without writing HI/LO
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         hi_q         <= 32'd0;
         lo_q         <= 32'd0;
         cnt_q        <= 5'd0;
         opa_q        <= 32'd0;
         opb_q        <= 32'd0;
         rem_q        <= 32'd0;
         res_hi_q     <= 32'd0;
         res_lo_q     <= 32'd0;
         mul_signed_q <= 1'b0;
         neg_quot_q   <= 1'b0;
         neg_rem_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         hi_q         <= hi_d;
         lo_q         <= lo_d;
         cnt_q        <= cnt_d;
         opa_q        <= opa_d;
         opb_q        <= opb_d;
         rem_q        <= rem_d;
         res_hi_q     <= res_hi_d;
         res_lo_q     <= res_lo_d;
         mul_signed_q <= mul_signed_d;
         neg_quot_q   <= neg_quot_d;
         neg_rem_q    <= neg_rem_d;
      end
   end
endmodule
